axis_adc_acq_ctrl: RTL
======================

Name: axis_adc_acq_ctrl

Overview:
Acquisition controller that sits downstream of the dual-channel ADC AXI-Stream front end. It arms on command, waits for a trigger (software, channel-A level crossing, or external), waits a programmable delay, then gates exactly N paired samples onto one packed AXI-Stream with TLAST. It also reports state, sample count and overrun to the register bank.

Parameters:
AXIS_TDATA_WIDTH, 16, width of each ADC input stream (sign-extended samples).
CNTR_WIDTH, 32, width of the delay/length/count counters.

Ports:
aclk  in  1  ADC-domain clock; all logic on rising edge.
aresetn  in  1  asynchronous active-low reset.
s00_axis_tvalid  in  1  channel A sample valid; no tready, the source cannot stall.
s00_axis_tdata  in  AXIS_TDATA_WIDTH  channel A sample, signed.
s01_axis_tvalid  in  1  channel B sample valid.
s01_axis_tdata  in  AXIS_TDATA_WIDTH  channel B sample, signed.
cfg_arm  in  1  single-cycle arm pulse.
cfg_abort  in  1  single-cycle abort pulse.
cfg_trig_src  in  2  0=software, 1=channel A level, 2=external, 3=reserved (never fires).
cfg_trig_edge  in  1  0=rising, 1=falling (level source only).
cfg_trig_level  in  AXIS_TDATA_WIDTH  signed threshold.
cfg_delay  in  CNTR_WIDTH  samples to skip after trigger.
cfg_length  in  CNTR_WIDTH  samples to capture.
sw_trig  in  1  software trigger pulse.
ext_trig  in  1  external trigger level, already synchronised to aclk.
m_axis_tready  in  1  downstream ready.
m_axis_tvalid  out  1  output beat valid.
m_axis_tdata  out  2*AXIS_TDATA_WIDTH  {chB, chA}.
m_axis_tlast  out  1  final beat of acquisition.
sts_state  out  3  current state encoding.
sts_count  out  CNTR_WIDTH  samples captured in current/last acquisition.
sts_overrun  out  1  sticky overrun, cleared by next accepted arm.

Behaviour:
- Reset: state IDLE; m_axis_tvalid, m_axis_tlast, sts_overrun = 0; m_axis_tdata, sts_count = 0; all counters 0.
- Sample strobe = s00_axis_tvalid & s01_axis_tvalid; states advance only on strobes except arm, abort and output handshake.
- States (sts_state): IDLE=0, ARMED=1, DELAY=2, CAPTURE=3, DONE=4.
- Arm:
  - Accepted in IDLE or DONE only, and only if cfg_length != 0; otherwise ignored.
  - On accept: latch all cfg_*; clear sts_count, sts_overrun and prev-sample-valid flag; go to ARMED.
  - Ignored in ARMED, DELAY and CAPTURE.
- Trigger, evaluated only in ARMED:
  - Software: sw_trig high on any cycle.
  - External: ext_trig rising edge (registered previous value; previous value reset to 0 on arm).
  - Level: on a strobe with prev-sample-valid set. Rising fires when prev < level and cur >= level; falling fires when prev > level and cur <= level; signed compare. The first strobe after arm only loads prev.
- Trigger sample index t: first captured sample is t+1+delay. Trigger → DELAY if latched delay > 0, else → CAPTURE. DELAY counts strobes down to 0, then → CAPTURE.
- CAPTURE:
  - Each strobe registers {s01_tdata, s00_tdata} onto m_axis, so latency is 1 cycle from strobe to tvalid, and increments sts_count.
  - The sample making sts_count == length sets tlast; state → DONE.
- Output hold:
  - tvalid stays high and data stays stable until tready.
  - tvalid and tlast clear on handshake unless a new beat loads in the same cycle.
- Overrun:
  - Trigger: a CAPTURE strobe while m_axis_tvalid & !m_axis_tready.
  - Result: new sample dropped; sts_overrun=1; state → DONE immediately; the pending beat completes without tlast (truncated packet).
- DONE: holds until arm.
- Abort, any state: → IDLE. A pending output beat remains valid until accepted; no new beats. Abort beats arm in the same cycle.
- Wrap: counters never wrap; length is bounded by CNTR_WIDTH.
- Reset mid-operation: asynchronous; the output beat is discarded.

Decomposition:
- Package axis_adc_acq_pkg: state encoding enum/localparams (IDLE..DONE) and trigger-source codes (TRIG_SW, TRIG_LEVEL, TRIG_EXT).
- Sub-module axis_adc_trig_detect: edge/level comparator with prev-sample register, enable and clear inputs, single-cycle fire output.

Test Plan:
- Level trigger: source=1, rising, level=100, delay=0, length=4; chA ramp 96,98,…; tready=1 → the first beat carries the sample after the first sample >=100; 4 beats; tlast on beat 4; state DONE; sts_count=4.
- Delay: software trigger on a strobe with index t; delay=3, length=2 → beats carry samples t+4 and t+5; tlast on the second beat.
- Backpressure and overrun: length=8; tready held low after beat 2 → sts_overrun=1; state DONE; beat 2 held until tready; no tlast seen; re-arm clears overrun.
- External trigger plus re-arm: ext_trig held high through arm → no trigger; low then high → trigger fires; arm pulses during CAPTURE are ignored; arm in DONE restarts with sts_count=0.
- Abort and arm in the same cycle during DELAY → IDLE; no beats emitted. cfg_length=0 arm → stays IDLE.
- aresetn asserted mid-CAPTURE with tvalid high → tvalid=0 and state IDLE immediately, asynchronously; reset values match the Behaviour list.

Source files
------------

// File: rtl/axis_adc_acq_pkg.sv
// Shared encodings for the ADC acquisition controller: FSM states reported on sts_state
// and the trigger-source codes carried by cfg_trig_src.
package axis_adc_acq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_DELAY   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } acq_state_t;

    localparam logic [1:0] TRIG_SW    = 2'd0;
    localparam logic [1:0] TRIG_LEVEL = 2'd1;
    localparam logic [1:0] TRIG_EXT   = 2'd2;

endpackage

// File: rtl/axis_adc_trig_detect.sv
// Trigger detector: software pulse, signed channel-A level crossing or external rising edge.
// Fire is combinational in the enabled cycle; no backpressure, clr_i restarts edge history.
module axis_adc_trig_detect
    import axis_adc_acq_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic                clr_i,
    input  logic                strobe_i,
    input  logic signed [W-1:0] sample_i,
    input  logic signed [W-1:0] level_i,
    input  logic [1:0]          src_i,
    input  logic                edge_i,
    input  logic                sw_trig_i,
    input  logic                ext_trig_i,
    output logic                fire_o
);

    logic signed [W-1:0] prev_q;
    logic                prev_vld_q;
    logic                ext_prev_q;
    logic                ext_seen_q;
    logic                cross_rise;
    logic                cross_fall;
    logic                level_fire;
    logic                ext_fire;

    // ext_seen_q makes the first armed cycle only sample ext_trig, so a level
    // already high at arm time is not mistaken for a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            ext_prev_q <= 1'b0;
            ext_seen_q <= 1'b0;
        end else if (clr_i) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            ext_prev_q <= 1'b0;
            ext_seen_q <= 1'b0;
        end else if (en_i) begin
            if (strobe_i) begin
                prev_q     <= sample_i;
                prev_vld_q <= 1'b1;
            end
            ext_prev_q <= ext_trig_i;
            ext_seen_q <= 1'b1;
        end
    end

    always_comb begin
        cross_rise = (prev_q < level_i) && (sample_i >= level_i);
        cross_fall = (prev_q > level_i) && (sample_i <= level_i);
        level_fire = strobe_i && prev_vld_q && (edge_i ? cross_fall : cross_rise);
        ext_fire   = ext_seen_q && ext_trig_i && !ext_prev_q;
        fire_o     = 1'b0;
        case (src_i)
            TRIG_SW:    fire_o = en_i && sw_trig_i;
            TRIG_LEVEL: fire_o = en_i && level_fire;
            TRIG_EXT:   fire_o = en_i && ext_fire;
            default:    fire_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/axis_adc_acq_ctrl.sv
// Arm/trigger/delay/capture controller gating N paired ADC samples onto one AXI-Stream packet.
// Strobe-to-tvalid latency 1 cycle; a strobe while the output stalls ends the capture as overrun.
module axis_adc_acq_ctrl
    import axis_adc_acq_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int CNTR_WIDTH       = 32
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          s00_axis_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic                          s01_axis_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0]   s01_axis_tdata,
    input  logic                          cfg_arm,
    input  logic                          cfg_abort,
    input  logic [1:0]                    cfg_trig_src,
    input  logic                          cfg_trig_edge,
    input  logic [AXIS_TDATA_WIDTH-1:0]   cfg_trig_level,
    input  logic [CNTR_WIDTH-1:0]         cfg_delay,
    input  logic [CNTR_WIDTH-1:0]         cfg_length,
    input  logic                          sw_trig,
    input  logic                          ext_trig,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tvalid,
    output logic [2*AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tlast,
    output logic [2:0]                    sts_state,
    output logic [CNTR_WIDTH-1:0]         sts_count,
    output logic                          sts_overrun
);

    acq_state_t                    state_q;
    logic [1:0]                    trig_src_q;
    logic                          trig_edge_q;
    logic [AXIS_TDATA_WIDTH-1:0]   trig_level_q;
    logic [CNTR_WIDTH-1:0]         delay_q;
    logic [CNTR_WIDTH-1:0]         length_q;
    logic [CNTR_WIDTH-1:0]         dcnt_q;
    logic [CNTR_WIDTH-1:0]         count_q;
    logic [CNTR_WIDTH-1:0]         count_d;
    logic                          tvalid_q;
    logic                          tlast_q;
    logic [2*AXIS_TDATA_WIDTH-1:0] tdata_q;
    logic                          overrun_q;

    logic strobe;
    logic arm_acc;
    logic out_stall;
    logic handshake;
    logic fire;

    always_comb begin
        strobe    = s00_axis_tvalid && s01_axis_tvalid;
        arm_acc   = cfg_arm && !cfg_abort && (cfg_length != '0) &&
                    ((state_q == ST_IDLE) || (state_q == ST_DONE));
        out_stall = tvalid_q && !m_axis_tready;
        handshake = tvalid_q && m_axis_tready;
        count_d   = count_q + CNTR_WIDTH'(1);
    end

    axis_adc_trig_detect #(
        .W (AXIS_TDATA_WIDTH)
    ) u_trig (
        .clk        (aclk),
        .rst_n      (aresetn),
        .en_i       (state_q == ST_ARMED),
        .clr_i      (arm_acc),
        .strobe_i   (strobe),
        .sample_i   ($signed(s00_axis_tdata)),
        .level_i    ($signed(trig_level_q)),
        .src_i      (trig_src_q),
        .edge_i     (trig_edge_q),
        .sw_trig_i  (sw_trig),
        .ext_trig_i (ext_trig),
        .fire_o     (fire)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            trig_src_q   <= TRIG_SW;
            trig_edge_q  <= 1'b0;
            trig_level_q <= '0;
            delay_q      <= '0;
            length_q     <= '0;
            dcnt_q       <= '0;
            count_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tdata_q      <= '0;
            overrun_q    <= 1'b0;
        end else begin
            // A beat loaded below in the same cycle overrides this retire.
            if (handshake) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end
            if (cfg_abort) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (arm_acc) begin
                            trig_src_q   <= cfg_trig_src;
                            trig_edge_q  <= cfg_trig_edge;
                            trig_level_q <= cfg_trig_level;
                            delay_q      <= cfg_delay;
                            length_q     <= cfg_length;
                            count_q      <= '0;
                            overrun_q    <= 1'b0;
                            state_q      <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (fire) begin
                            if (delay_q != '0) begin
                                dcnt_q  <= delay_q;
                                state_q <= ST_DELAY;
                            end else begin
                                state_q <= ST_CAPTURE;
                            end
                        end
                    end
                    ST_DELAY: begin
                        if (strobe) begin
                            dcnt_q <= dcnt_q - CNTR_WIDTH'(1);
                            if (dcnt_q == CNTR_WIDTH'(1)) begin
                                state_q <= ST_CAPTURE;
                            end
                        end
                    end
                    ST_CAPTURE: begin
                        if (strobe) begin
                            if (out_stall) begin
                                overrun_q <= 1'b1;
                                state_q   <= ST_DONE;
                            end else begin
                                tdata_q  <= {s01_axis_tdata, s00_axis_tdata};
                                tvalid_q <= 1'b1;
                                tlast_q  <= (count_d == length_q);
                                count_q  <= count_d;
                                if (count_d == length_q) begin
                                    state_q <= ST_DONE;
                                end
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign sts_state     = state_q;
    assign sts_count     = count_q;
    assign sts_overrun   = overrun_q;

endmodule
